// File: rtl/sha256_padder.sv
// ---------------------------------------------------------------------------
// sha256_padder
// Turns a message of num_words 32-bit words into the padded SHA-256 word
// stream: message words, 0x80000000, zero fill, then the 64-bit bit length
// (high word, low word) as the last two words of the final 512-bit block.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, num_words  begin a message of num_words words (sampled in IDLE)
//   in_valid/in_ready/in_data     message word stream (ready/valid)
//   out_valid/out_ready/out_data  padded word stream (ready/valid)
//   out_last_word     word 15 of each block
//   out_last_block    every word of the final block
//   busy              accepted start .. done
//   done              one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module sha256_padder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_last_word,
    output logic        out_last_block,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, MSG, PAD1, ZERO, LEN_HI, LEN_LO} state_t;

    state_t      state;
    logic [15:0] nw_q;      // latched message length
    logic [16:0] beat_idx;  // index of the next beat to be loaded
    logic        lo_sent;   // LEN_LO word sits in the output register

    logic [16:0] nb;
    logic [16:0] total;
    logic [16:0] last_blk;
    logic        ld_ok;
    logic        acc;
    logic        ld;
    logic [31:0] ld_data;

    // NB = ceil((n+3)/16) = (n+18)>>4; all in 17 bits, max total 65552.
    assign nb       = ({1'b0, nw_q} + 17'd18) >> 4;
    assign total    = nb << 4;
    assign last_blk = total - 17'd16;

    // Output register can take a new word when empty or being drained.
    assign ld_ok    = !out_valid || out_ready;
    assign acc      = out_valid && out_ready;
    assign in_ready = (state == MSG) && ld_ok;

    // Word to load into the output register this cycle, per state.
    always_comb begin
        ld      = 1'b0;
        ld_data = 32'h0;
        case (state)
            MSG: begin
                ld      = in_valid && ld_ok;
                ld_data = in_data;
            end
            PAD1: begin
                ld      = ld_ok;
                ld_data = 32'h8000_0000;
            end
            ZERO, LEN_HI: begin
                ld      = ld_ok;
                ld_data = 32'h0;
            end
            LEN_LO: begin
                ld      = ld_ok && !lo_sent;
                ld_data = {11'b0, nw_q, 5'b0};
            end
            default: begin
                ld      = 1'b0;
                ld_data = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            nw_q           <= 16'h0;
            beat_idx       <= 17'h0;
            lo_sent        <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= 32'h0;
            out_last_word  <= 1'b0;
            out_last_block <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;

            // Output register: load a new word or empty it after acceptance.
            if (ld) begin
                out_valid      <= 1'b1;
                out_data       <= ld_data;
                out_last_word  <= (beat_idx[3:0] == 4'hf);
                out_last_block <= (beat_idx >= last_blk);
                beat_idx       <= beat_idx + 17'd1;
            end else if (acc) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        nw_q     <= num_words;
                        beat_idx <= 17'h0;
                        lo_sent  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (num_words != 16'h0) ? MSG : PAD1;
                    end
                end
                MSG: begin
                    if (ld && (beat_idx == {1'b0, nw_q} - 17'd1))
                        state <= PAD1;
                end
                PAD1: begin
                    // beat_idx+3 == total: marker is immediately followed by
                    // the two length words, no zero fill needed.
                    if (ld)
                        state <= (beat_idx + 17'd3 == total) ? LEN_HI : ZERO;
                end
                ZERO: begin
                    if (ld && (beat_idx + 17'd3 == total))
                        state <= LEN_HI;
                end
                LEN_HI: begin
                    if (ld)
                        state <= LEN_LO;
                end
                LEN_LO: begin
                    if (ld) begin
                        lo_sent <= 1'b1;
                    end else if (lo_sent && acc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
